// File: rtl/data_streamer_pkg.sv
// ds_pkg: shared widths for the data_streamer bit-packing stage.
package ds_pkg;
    localparam int DS_IN_W  = 272;
    localparam int DS_OUT_W = 256;
    localparam int DS_LEN_W = 8;
    localparam int DS_CNT_W = 9;
    localparam int DS_BUF_W = 512;
endpackage

// File: rtl/ds_shift_merge.sv
// ds_shift_merge: masks a chunk to len bits, shifts it to offset cnt and ORs it into the buffer.
module ds_shift_merge
    import ds_pkg::*;
(
    input  logic [DS_IN_W-1:0]  dataIn,
    input  logic [DS_LEN_W-1:0] len,
    input  logic [DS_BUF_W-1:0] bufIn,
    input  logic [DS_CNT_W-1:0] cnt,
    output logic [DS_BUF_W-1:0] merged,
    output logic [DS_CNT_W-1:0] total
);
    logic [DS_OUT_W-1:0] mask;
    logic [DS_IN_W-1:0]  masked;

    // len never exceeds 255, so bit 255 and everything above it are always dropped
    assign mask   = ~({DS_OUT_W{1'b1}} << len);
    assign masked = dataIn & {{(DS_IN_W-DS_OUT_W){1'b0}}, mask};
    assign merged = bufIn | ({{(DS_BUF_W-DS_IN_W){1'b0}}, masked} << cnt);
    assign total  = cnt + {1'b0, len};
endmodule

// File: rtl/data_streamer.sv
// data_streamer: packs variable-length chunks LSB-first and emits full 256-bit words.
module data_streamer
    import ds_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                wrtEn,
    input  logic [DS_IN_W-1:0]  dataIn,
    input  logic [DS_LEN_W-1:0] len,
    output logic [DS_OUT_W-1:0] dataOut,
    output logic                valid,
    output logic [DS_CNT_W-1:0] newLen
);
    logic [DS_BUF_W-1:0] bufReg;
    logic [DS_CNT_W-1:0] cnt;
    logic [DS_BUF_W-1:0] merged;
    logic [DS_CNT_W-1:0] total;

    ds_shift_merge u_merge (
        .dataIn (dataIn),
        .len    (len),
        .bufIn  (bufReg),
        .cnt    (cnt),
        .merged (merged),
        .total  (total)
    );

    assign newLen = cnt;

    // total[8] set means at least one full word is available; total[7:0] is the leftover count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bufReg  <= '0;
            cnt     <= '0;
            dataOut <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (wrtEn) begin
                if (total[DS_CNT_W-1]) begin
                    dataOut <= merged[DS_OUT_W-1:0];
                    valid   <= 1'b1;
                    bufReg  <= {{(DS_BUF_W-DS_OUT_W){1'b0}}, merged[DS_BUF_W-1:DS_OUT_W]};
                    cnt     <= {1'b0, total[DS_CNT_W-2:0]};
                end else begin
                    bufReg <= merged;
                    cnt    <= total;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_streamer.sv
// tb_data_streamer: bit-queue reference model with a word scoreboard for data_streamer.
module tb_data_streamer;
    logic         clk = 1'b0;
    logic         reset;
    logic         wrtEn;
    logic [271:0] dataIn;
    logic [7:0]   len;
    logic [255:0] dataOut;
    logic         valid;
    logic [8:0]   newLen;

    int           vectors = 0;
    int           miscompares = 0;
    bit           bitQ[$];
    logic [255:0] expQ[$];
    logic [255:0] lastWord;

    data_streamer dut (
        .clk     (clk),
        .reset   (reset),
        .wrtEn   (wrtEn),
        .dataIn  (dataIn),
        .len     (len),
        .dataOut (dataOut),
        .valid   (valid),
        .newLen  (newLen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [271:0] rnd272();
        logic [271:0] d;
        for (int i = 0; i < 9; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic step(input logic we, input logic [7:0] l, input logic [271:0] d);
        bit           expV;
        logic [255:0] w;
        wrtEn  = we;
        len    = l;
        dataIn = d;
        @(posedge clk);
        #1;
        expV = 1'b0;
        if (we) begin
            for (int i = 0; i < int'(l); i++) bitQ.push_back(d[i]);
            if (bitQ.size() >= 256) begin
                for (int i = 0; i < 256; i++) w[i] = bitQ.pop_front();
                expQ.push_back(w);
                expV = 1'b1;
            end
        end
        check("valid", {255'b0, valid}, {255'b0, expV});
        check("newLen", {247'b0, newLen}, 256'(bitQ.size()));
        if (valid) begin
            check("wordAvail", 256'(expQ.size()), 256'd1);
            if (expQ.size() > 0) begin
                w = expQ.pop_front();
                check("dataOut", dataOut, w);
                lastWord = w;
            end
        end else begin
            check("dataOutHold", dataOut, lastWord);
        end
    endtask

    task automatic modelReset();
        bitQ.delete();
        expQ.delete();
        lastWord = '0;
    endtask

    initial begin
        logic [255:0] ones;
        reset  = 1'b1;
        wrtEn  = 1'b0;
        len    = '0;
        dataIn = '0;
        modelReset();
        #12;
        check("rstDataOut", dataOut, 256'd0);
        check("rstValid", {255'b0, valid}, 256'd0);
        check("rstNewLen", {247'b0, newLen}, 256'd0);
        reset = 1'b0;

        for (int k = 0; k < 6; k++) step(1'b1, 8'd16, '0);

        #2 reset = 1'b1;
        #1;
        check("asyncDataOut", dataOut, 256'd0);
        check("asyncValid", {255'b0, valid}, 256'd0);
        check("asyncNewLen", {247'b0, newLen}, 256'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        modelReset();

        for (int k = 0; k < 16; k++) step(1'b1, 8'd16, 272'(k));
        for (int k = 0; k < 16; k++) check("slice", {240'b0, dataOut[16*k +: 16]}, 256'(k));
        step(1'b0, 8'd0, '0);

        step(1'b1, 8'd200, '1);
        step(1'b1, 8'd200, '1);
        ones = '1;
        check("onesWord", dataOut, ones);
        step(1'b1, 8'd112, '0);

        for (int k = 0; k < 64; k++) step(1'b1, 8'd4, 272'hFF);
        check("nibbleWord", dataOut, ones);
        check("nibbleCnt", {247'b0, newLen}, 256'd0);

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       step(1'b0, 8'($urandom), rnd272());
                1:       step(1'b1, 8'd0, rnd272());
                default: step(1'b1, 8'($urandom), rnd272());
            endcase
        end

        check("pendingWords", 256'(expQ.size()), 256'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
